// File: rtl/arcade_input_pkg.sv
// ---------------------------------------------------------------------------
// arcade_input_pkg
//   Shared types and helpers for the arcade input controller.
//   - src_sel_e     : input source selection (USB / DB9 Mega Drive / DB15).
//   - coin_state_e  : states of the per-player coin pulse shaper.
//   - canonical 16-bit controller word layout, as functions of the number of
//     action buttons per player:
//       [3:0]                directions (bit0 R, bit1 L, bit2 D, bit3 U)
//       [4 +: num_btn]       action buttons
//       4+num_btn            start
//       5+num_btn            coin
//       6+num_btn            pause
//       remaining bits       ignored
// ---------------------------------------------------------------------------
package arcade_input_pkg;

    typedef enum logic [1:0] {
        SRC_USB   = 2'd0,
        SRC_DB9MD = 2'd1,
        SRC_DB15  = 2'd2,
        SRC_RSVD  = 2'd3   // behaves as USB
    } src_sel_e;

    typedef enum logic [1:0] {
        COIN_ST_IDLE,
        COIN_ST_HOLD,
        COIN_ST_WAIT_REL
    } coin_state_e;

    localparam int unsigned CANON_W = 16;
    localparam int unsigned DIR_LSB = 0;
    localparam int unsigned DIR_W   = 4;
    localparam int unsigned BTN_LSB = 4;

    function automatic int unsigned start_bit(input int unsigned num_btn);
        return BTN_LSB + num_btn;
    endfunction

    function automatic int unsigned coin_bit(input int unsigned num_btn);
        return BTN_LSB + num_btn + 1;
    endfunction

    function automatic int unsigned pause_bit(input int unsigned num_btn);
        return BTN_LSB + num_btn + 2;
    endfunction

    // Both DB connector flavours route player 0 from the DB ports.
    function automatic logic src_is_db(input src_sel_e sel);
        return (sel == SRC_DB9MD) || (sel == SRC_DB15);
    endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin_pulse.sv
// ---------------------------------------------------------------------------
// coin_pulse
//   Shapes a raw coin level into a fixed-width pulse of exactly COIN_HOLD
//   clk_sys cycles per accepted press, whatever the press length.
//   A press is accepted on a rising edge seen while idle; edges during the
//   pulse are ignored, and a coin still held when the pulse ends must be
//   released before another press is accepted.
//
//   Ports:
//     clk_sys   in   system clock
//     reset     in   synchronous, active-high
//     coin_in   in   raw (unregistered) coin level
//     coin_out  out  shaped coin pulse, high the cycle after the accepted edge
// ---------------------------------------------------------------------------
module coin_pulse
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_HOLD = 1800000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic coin_in,
    output logic coin_out
);

    localparam int unsigned CW = (COIN_HOLD > 1) ? $clog2(COIN_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(COIN_HOLD - 1);

    coin_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          coin_prev;
    logic          coin_rise;

    assign coin_rise = coin_in & ~coin_prev;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= COIN_ST_IDLE;
            cnt_q     <= '0;
            coin_prev <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            coin_prev <= coin_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            COIN_ST_IDLE: begin
                if (coin_rise) begin
                    state_d = COIN_ST_HOLD;
                    cnt_d   = CNT_LOAD;
                end
            end
            COIN_ST_HOLD: begin
                // Counter runs COIN_HOLD-1 down to 0, one HOLD cycle per value.
                if (cnt_q == '0) begin
                    state_d = coin_in ? COIN_ST_WAIT_REL : COIN_ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COIN_ST_WAIT_REL: begin
                if (!coin_in) begin
                    state_d = COIN_ST_IDLE;
                end
            end
            default: begin
                state_d = COIN_ST_IDLE;
            end
        endcase
    end

    assign coin_out = (state_q == COIN_ST_HOLD);

endmodule

// File: rtl/arcade_input_ctrl.sv
// ---------------------------------------------------------------------------
// arcade_input_ctrl
//   Merges USB pads, two DB controller ports and keyboard mappings into
//   per-player direction, button, start and coin signals, with per-button
//   autofire, coin pulse shaping, a pause toggle pulse and an OSD combo.
//
//   Parameters:
//     NUM_PLAYERS   1..4   player slots
//     NUM_BTN       1..8   action buttons per player
//     COIN_HOLD            coin pulse width in clk_sys cycles
//     AUTOFIRE_DIV         clk_sys cycles per autofire phase
//
//   Ports:
//     clk_sys        in   system clock (only clock)
//     reset          in   synchronous, active-high
//     src_sel        in   0 USB, 1 DB9MD, 2 DB15, 3 as USB
//     two_player_db  in   DB port 2 feeds player 1
//     joy_usb        in   NUM_PLAYERS canonical words from USB pads
//     joy_db         in   2 canonical words from DB ports 1 and 2
//     key_vec        in   NUM_PLAYERS canonical words from keyboard
//     autofire_en    in   per-button autofire enable
//     p_dir          out  4 direction bits per player
//     p_btn          out  NUM_BTN action buttons per player
//     p_start        out  start per player
//     p_coin         out  shaped coin pulse per player
//     pause_toggle   out  one-cycle pulse per pause press (any player)
//     osd_req        out  DB port 1 Start+Coin held
// ---------------------------------------------------------------------------
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = 2,
    parameter int unsigned NUM_BTN      = 2,
    parameter int unsigned COIN_HOLD    = 1800000,
    parameter int unsigned AUTOFIRE_DIV = 600000
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic [1:0]                     src_sel,
    input  logic                           two_player_db,
    input  logic [NUM_PLAYERS*16-1:0]      joy_usb,
    input  logic [2*16-1:0]                joy_db,
    input  logic [NUM_PLAYERS*16-1:0]      key_vec,
    input  logic [NUM_BTN-1:0]             autofire_en,
    output logic [NUM_PLAYERS*4-1:0]       p_dir,
    output logic [NUM_PLAYERS*NUM_BTN-1:0] p_btn,
    output logic [NUM_PLAYERS-1:0]         p_start,
    output logic [NUM_PLAYERS-1:0]         p_coin,
    output logic                           pause_toggle,
    output logic                           osd_req
);

    localparam int unsigned START_BIT = start_bit(NUM_BTN);
    localparam int unsigned COIN_BIT  = coin_bit(NUM_BTN);
    localparam int unsigned PAUSE_BIT = pause_bit(NUM_BTN);

    localparam int unsigned AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_DIV - 1);

    // Bits above the pause position carry nothing for this block.
    logic unused_inputs;
    assign unused_inputs = ^{joy_usb, joy_db, key_vec};

    // -----------------------------------------------------------------------
    // Source routing and keyboard merge (combinational)
    // -----------------------------------------------------------------------
    logic                           use_db;
    int unsigned                    usb_shift;
    int unsigned                    usb_idx;
    logic [CANON_W-1:0]             slot_w;
    logic                           slot_from_db;
    logic [NUM_PLAYERS*4-1:0]       dir_d;
    logic [NUM_PLAYERS*NUM_BTN-1:0] btn_d;
    logic [NUM_PLAYERS-1:0]         start_d;
    logic [NUM_PLAYERS-1:0]         coin_raw;
    logic                           pause_any;

    logic [AW-1:0] af_cnt;
    logic          af_phase;
    logic          pause_prev;

    always_comb begin
        use_db       = src_is_db(src_sel_e'(src_sel));
        // With DB routing, USB pads shift up by the number of DB-fed slots.
        usb_shift    = use_db ? (two_player_db ? 2 : 1) : 0;
        usb_idx      = 0;
        slot_w       = '0;
        slot_from_db = 1'b0;
        dir_d        = '0;
        btn_d        = '0;
        start_d      = '0;
        coin_raw     = '0;
        pause_any    = 1'b0;

        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            slot_from_db = 1'b0;
            usb_idx      = (i >= usb_shift) ? (i - usb_shift) : 0;
            if (use_db && (i == 0)) begin
                slot_w       = joy_db[0 +: CANON_W];
                slot_from_db = 1'b1;
            end else if (use_db && two_player_db && (i == 1)) begin
                slot_w       = joy_db[CANON_W +: CANON_W];
                slot_from_db = 1'b1;
            end else begin
                slot_w = joy_usb[usb_idx*CANON_W +: CANON_W];
            end

            // DB pads lack a coin button; Start+Button0 stands in for it.
            if (slot_from_db) begin
                slot_w[COIN_BIT] = slot_w[COIN_BIT] |
                                   (slot_w[START_BIT] & slot_w[BTN_LSB]);
            end

            slot_w = slot_w | key_vec[i*CANON_W +: CANON_W];

            dir_d[i*DIR_W +: DIR_W] = slot_w[DIR_LSB +: DIR_W];
            for (int unsigned b = 0; b < NUM_BTN; b++) begin
                btn_d[i*NUM_BTN + b] = slot_w[BTN_LSB + b] &
                                       (~autofire_en[b] | af_phase);
            end
            start_d[i]  = slot_w[START_BIT];
            coin_raw[i] = slot_w[COIN_BIT];
            pause_any   = pause_any | slot_w[PAUSE_BIT];
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs, autofire timebase, pause edge detect
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt       <= '0;
            af_phase     <= 1'b0;
            p_dir        <= '0;
            p_btn        <= '0;
            p_start      <= '0;
            osd_req      <= 1'b0;
            pause_prev   <= 1'b0;
            pause_toggle <= 1'b0;
        end else begin
            if (af_cnt == AF_LAST) begin
                af_cnt   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_cnt <= af_cnt + 1'b1;
            end

            p_dir        <= dir_d;
            p_btn        <= btn_d;
            p_start      <= start_d;
            // Taken straight from DB port 1, independent of src_sel.
            osd_req      <= joy_db[START_BIT] & joy_db[COIN_BIT];
            pause_prev   <= pause_any;
            pause_toggle <= pause_any & ~pause_prev;
        end
    end

    // -----------------------------------------------------------------------
    // Coin pulse shaping, one per player
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_coin
        coin_pulse #(
            .COIN_HOLD(COIN_HOLD)
        ) u_coin_pulse (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .coin_in  (coin_raw[g]),
            .coin_out (p_coin[g])
        );
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arcade_input_ctrl
//   Self-checking bench for arcade_input_ctrl with NUM_PLAYERS=2, NUM_BTN=2,
//   COIN_HOLD=10, AUTOFIRE_DIV=4. Canonical layout for NUM_BTN=2:
//   dir [3:0], btn [5:4], start 6, coin 7, pause 8.
// ---------------------------------------------------------------------------
module tb_arcade_input_ctrl;

    localparam int HOLD = 10;
    localparam int DIV  = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [1:0]  src_sel;
    logic        two_player_db;
    logic [31:0] joy_usb;
    logic [31:0] joy_db;
    logic [31:0] key_vec;
    logic [1:0]  autofire_en;
    logic [7:0]  p_dir;
    logic [3:0]  p_btn;
    logic [1:0]  p_start;
    logic [1:0]  p_coin;
    logic        pause_toggle;
    logic        osd_req;

    int n_checks = 0;
    int n_fail   = 0;

    arcade_input_ctrl #(
        .NUM_PLAYERS (2),
        .NUM_BTN     (2),
        .COIN_HOLD   (HOLD),
        .AUTOFIRE_DIV(DIV)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .src_sel      (src_sel),
        .two_player_db(two_player_db),
        .joy_usb      (joy_usb),
        .joy_db       (joy_db),
        .key_vec      (key_vec),
        .autofire_en  (autofire_en),
        .p_dir        (p_dir),
        .p_btn        (p_btn),
        .p_start      (p_start),
        .p_coin       (p_coin),
        .pause_toggle (pause_toggle),
        .osd_req      (osd_req)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        src_sel       = 2'd0;
        two_player_db = 1'b0;
        joy_usb       = '0;
        joy_db        = '0;
        key_vec       = '0;
        autofire_en   = '0;
    endtask

    // Leaves the bench 1 time unit after the last reset edge, reset released.
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk_sys);
        #1;
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference: canonical word seen by player p, from the routing rules.
    function automatic logic [15:0] ref_slot(input int p, input logic [1:0] ss, input logic tp,
                                             input logic [31:0] usb, input logic [31:0] db,
                                             input logic [31:0] key);
        logic [15:0] w;
        logic        from_db;
        int          u;
        from_db = 1'b0;
        if (ss == 2'd1 || ss == 2'd2) begin
            if (p == 0) begin
                w = db[15:0];
                from_db = 1'b1;
            end else if (tp && p == 1) begin
                w = db[31:16];
                from_db = 1'b1;
            end else begin
                u = tp ? p - 2 : p - 1;
                w = usb[u*16 +: 16];
            end
        end else begin
            w = usb[p*16 +: 16];
        end
        if (from_db && w[6] && w[4]) w[7] = 1'b1;
        return w | key[p*16 +: 16];
    endfunction

    typedef struct {
        logic [1:0]  ss;
        logic        tp;
        logic [31:0] usb;
        logic [31:0] db;
        logic [31:0] key;
        logic [7:0]  dir;
        logic [3:0]  btn;
        logic [1:0]  st;
        logic        osd;
    } vec_t;

    vec_t tbl [7];

    initial begin
        // ---------------- reset state, with busy inputs ----------------
        reset         = 1'b1;
        src_sel       = 2'd0;
        two_player_db = 1'b0;
        joy_usb       = 32'hFFFF_FFFF;
        joy_db        = 32'hFFFF_FFFF;
        key_vec       = 32'hFFFF_FFFF;
        autofire_en   = 2'b00;
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_p_dir",   32'(p_dir),        32'h0);
        check("reset_p_btn",   32'(p_btn),        32'h0);
        check("reset_p_start", 32'(p_start),      32'h0);
        check("reset_p_coin",  32'(p_coin),       32'h0);
        check("reset_pause",   32'(pause_toggle), 32'h0);
        check("reset_osd",     32'(osd_req),      32'h0);

        // ---------------- table-driven routing vectors ----------------
        tbl[0] = '{2'd0, 1'b0, 32'h0018_0001, 32'h0000_0000, 32'h0000_0000, 8'h81, 4'b0100, 2'b00, 1'b0};
        tbl[1] = '{2'd1, 1'b0, 32'h000F_0002, 32'h0000_0044, 32'h0000_0000, 8'h24, 4'b0000, 2'b01, 1'b0};
        tbl[2] = '{2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0060_0001, 32'h0000_0000, 8'h01, 4'b1000, 2'b10, 1'b0};
        tbl[3] = '{2'd3, 1'b0, 32'h0000_0020, 32'h0000_00C0, 32'h0000_0000, 8'h00, 4'b0010, 2'b00, 1'b1};
        tbl[4] = '{2'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0003_0050, 8'h30, 4'b0001, 2'b01, 1'b0};
        tbl[5] = '{2'd1, 1'b1, 32'h0000_0004, 32'h0001_0008, 32'h0000_0000, 8'h18, 4'b0000, 2'b00, 1'b0};
        tbl[6] = '{2'd2, 1'b0, 32'h0000_0104, 32'h0000_0002, 32'h0001_0000, 8'h52, 4'b0000, 2'b00, 1'b0};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            src_sel       = tbl[i].ss;
            two_player_db = tbl[i].tp;
            joy_usb       = tbl[i].usb;
            joy_db        = tbl[i].db;
            key_vec       = tbl[i].key;
            autofire_en   = 2'b00;
            tick();
            check($sformatf("tbl%0d_dir", i),   32'(p_dir),   32'(tbl[i].dir));
            check($sformatf("tbl%0d_btn", i),   32'(p_btn),   32'(tbl[i].btn));
            check($sformatf("tbl%0d_start", i), 32'(p_start), 32'(tbl[i].st));
            check($sformatf("tbl%0d_osd", i),   32'(osd_req), 32'(tbl[i].osd));
        end

        // ---------------- short coin press: 3 cycles ----------------
        do_reset();
        check("coin_short_pre", 32'(p_coin[0]), 32'h0);
        joy_usb = 32'h0000_0080;
        for (int j = 1; j <= 20; j++) begin
            tick();
            check($sformatf("coin_short_c%0d", j), 32'(p_coin[0]), 32'((j >= 1 && j <= HOLD) ? 1 : 0));
            if (j == 3) joy_usb = 32'h0;
        end

        // ---------------- long coin hold, release, re-press ----------------
        do_reset();
        joy_usb = 32'h0000_0080;
        for (int j = 1; j <= 50; j++) begin
            tick();
            check($sformatf("coin_long_c%0d", j), 32'(p_coin[0]),
                  32'(((j <= HOLD) || (j >= 36 && j <= 35 + HOLD)) ? 1 : 0));
            if (j == 30) joy_usb = 32'h0;
            if (j == 35) joy_usb = 32'h0000_0080;
        end

        // ---------------- DB start+button0 coin, USB up on player 1 ----------------
        do_reset();
        src_sel       = 2'd1;
        two_player_db = 1'b0;
        joy_db        = 32'h0000_0050;
        joy_usb       = 32'h0000_0008;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 1) begin
                check("db_dir_p1",   32'(p_dir[7:4]), 32'h8);
                check("db_start_p0", 32'(p_start[0]), 32'h1);
            end
            check($sformatf("db_coin_c%0d", j), 32'(p_coin[0]), 32'((j <= HOLD) ? 1 : 0));
        end

        // ---------------- autofire ----------------
        do_reset();
        autofire_en = 2'b01;
        joy_usb     = 32'h0000_0030;
        for (int j = 1; j <= 24; j++) begin
            tick();
            check($sformatf("af_btn0_c%0d", j), 32'(p_btn[0]), 32'(((j - 1) / DIV) % 2));
            check($sformatf("af_btn1_c%0d", j), 32'(p_btn[1]), 32'h1);
        end

        // ---------------- simultaneous pause ----------------
        do_reset();
        joy_usb = 32'h0100_0100;
        for (int j = 1; j <= 5; j++) begin
            tick();
            check($sformatf("pause_both_c%0d", j), 32'(pause_toggle), 32'((j == 1) ? 1 : 0));
        end
        joy_usb = 32'h0;
        tick();
        tick();
        joy_usb = 32'h0000_0100;
        tick();
        check("pause_p0_only", 32'(pause_toggle), 32'h1);
        joy_usb = 32'h0100_0100;
        tick();
        check("pause_p1_joins", 32'(pause_toggle), 32'h0);
        tick();
        check("pause_held", 32'(pause_toggle), 32'h0);

        // ---------------- reset during HOLD ----------------
        do_reset();
        joy_usb = 32'h0000_0080;
        for (int j = 1; j <= 5; j++) begin
            tick();
            check($sformatf("rst_hold_c%0d", j), 32'(p_coin[0]), 32'h1);
        end
        reset = 1'b1;
        tick();
        check("rst_hold_drop", 32'(p_coin[0]), 32'h0);
        reset = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            check($sformatf("rst_hold_new_c%0d", j), 32'(p_coin[0]), 32'((j <= HOLD) ? 1 : 0));
        end

        // ---------------- randomized run against reference model ----------------
        do_reset();
        begin
            int          af_n;
            int          rem [2];
            logic        cprev [2];
            logic        pprev;
            logic [15:0] w [2];
            logic [7:0]  e_dir;
            logic [3:0]  e_btn;
            logic [1:0]  e_st;
            logic [1:0]  e_coin;
            logic        e_pt;
            logic        e_osd;
            logic        phase;
            logic        pany;
            logic        rise;

            af_n     = 0;
            rem[0]   = 0;
            rem[1]   = 0;
            cprev[0] = 1'b0;
            cprev[1] = 1'b0;
            pprev    = 1'b0;

            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 15) == 0) src_sel = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) two_player_db = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 31) == 0) autofire_en = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) joy_usb = $urandom;
                if ($urandom_range(0, 1) == 0) joy_db = $urandom;
                key_vec = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;

                for (int p = 0; p < 2; p++)
                    w[p] = ref_slot(p, src_sel, two_player_db, joy_usb, joy_db, key_vec);

                phase = (((af_n / DIV) % 2) == 1);
                e_dir = {w[1][3:0], w[0][3:0]};
                e_st  = {w[1][6], w[0][6]};
                for (int p = 0; p < 2; p++)
                    for (int b = 0; b < 2; b++)
                        e_btn[p*2 + b] = w[p][4 + b] & (autofire_en[b] ? phase : 1'b1);
                e_osd = joy_db[6] & joy_db[7];
                pany  = w[0][8] | w[1][8];
                e_pt  = pany & ~pprev;
                pprev = pany;
                for (int p = 0; p < 2; p++) begin
                    rise     = w[p][7] & ~cprev[p];
                    cprev[p] = w[p][7];
                    if (rem[p] > 0) rem[p] = rem[p] - 1;
                    else if (rise)  rem[p] = HOLD;
                    e_coin[p] = (rem[p] > 0);
                end
                af_n++;

                tick();
                check($sformatf("rnd%0d_dir", k),   32'(p_dir),        32'(e_dir));
                check($sformatf("rnd%0d_btn", k),   32'(p_btn),        32'(e_btn));
                check($sformatf("rnd%0d_start", k), 32'(p_start),      32'(e_st));
                check($sformatf("rnd%0d_coin", k),  32'(p_coin),       32'(e_coin));
                check($sformatf("rnd%0d_pause", k), 32'(pause_toggle), 32'(e_pt));
                check($sformatf("rnd%0d_osd", k),   32'(osd_req),      32'(e_osd));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
